// File: rtl/neuron_readout_3x5.sv
// Readout controller for the 3x5 oscillator bank.
// Watches the bank's check strobes until the neuron states settle (or the
// check budget runs out), snapshots the phase vector, turns each phase
// relative to neuron 0 into a binary pixel and streams the pixels out over
// a valid/ready handshake.
module neuron_readout_3x5 #(
  parameter int N_NEUR        = 15,
  parameter int PW            = 4,
  parameter int STABLE_CHECKS = 8,
  parameter int MAX_CHECKS    = 1023
) (
  input  logic                   sclk,
  input  logic                   re_n,
  input  logic                   start,
  input  logic                   state_cheak,
  input  logic [0:N_NEUR-1]      state_changed,
  input  logic [0:N_NEUR*PW-1]   phi_out,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_pixel,
  output logic [3:0]             out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   timeout,
  output logic                   done
);

  localparam logic [7:0]  STABLE_C = 8'(STABLE_CHECKS);
  localparam logic [15:0] MAX_C    = 16'(MAX_CHECKS);
  localparam logic [3:0]  LAST_IDX = 4'(N_NEUR - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WATCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_reg,      state_next;
  logic [7:0]          stable_cnt_reg, stable_cnt_next;
  logic [15:0]         check_cnt_reg,  check_cnt_next;
  logic                timeout_reg,    timeout_next;
  logic [N_NEUR-1:0]   pixel_reg,      pixel_next;
  logic [3:0]          index_reg,      index_next;

  logic [N_NEUR-1:0]   pixel_dec;
  logic [7:0]          stable_inc;
  logic [15:0]         check_inc;
  logic                converge;
  logic                hit_max;

  // Phase-to-pixel decode: wrap-around difference to neuron 0, pixel set
  // when the neuron sits roughly in anti-phase (difference 4..11).
  generate
    for (genvar gi = 0; gi < N_NEUR; gi++) begin : g_decode
      if (gi == 0) begin : g_ref
        assign pixel_dec[gi] = 1'b0;
      end else begin : g_cmp
        logic [PW-1:0] diff;
        assign diff          = phi_out[PW*gi +: PW] - phi_out[0 +: PW];
        assign pixel_dec[gi] = (diff >= PW'(4)) && (diff <= PW'(11));
      end
    end
  endgenerate

  // Next-state and datapath updates for the readout FSM.
  always_comb begin
    state_next      = state_reg;
    stable_cnt_next = stable_cnt_reg;
    check_cnt_next  = check_cnt_reg;
    timeout_next    = timeout_reg;
    pixel_next      = pixel_reg;
    index_next      = index_reg;

    check_inc  = check_cnt_reg + 16'd1;
    stable_inc = 8'd0;
    if (!(|state_changed)) begin
      stable_inc = (stable_cnt_reg == STABLE_C) ? STABLE_C : stable_cnt_reg + 8'd1;
    end
    // Convergence wins when both conditions land on the same strobe.
    converge = (stable_inc == STABLE_C);
    hit_max  = !converge && (check_inc == MAX_C);

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          stable_cnt_next = 8'd0;
          check_cnt_next  = 16'd0;
          timeout_next    = 1'b0;
          state_next      = ST_WATCH;
        end
      end
      ST_WATCH: begin
        if (state_cheak) begin
          check_cnt_next  = check_inc;
          stable_cnt_next = stable_inc;
          if (converge || hit_max) begin
            pixel_next = pixel_dec;
            index_next = 4'd0;
            state_next = ST_STREAM;
            if (hit_max) begin
              timeout_next = 1'b1;
            end
          end
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (index_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            index_next = index_reg + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      state_reg      <= ST_IDLE;
      stable_cnt_reg <= 8'd0;
      check_cnt_reg  <= 16'd0;
      timeout_reg    <= 1'b0;
      pixel_reg      <= '0;
      index_reg      <= 4'd0;
    end else begin
      state_reg      <= state_next;
      stable_cnt_reg <= stable_cnt_next;
      check_cnt_reg  <= check_cnt_next;
      timeout_reg    <= timeout_next;
      pixel_reg      <= pixel_next;
      index_reg      <= index_next;
    end
  end

  // Outputs are decoded straight from registers so they hold during stalls.
  assign out_valid = (state_reg == ST_STREAM);
  assign out_pixel = out_valid & pixel_reg[index_reg];
  assign out_index = index_reg;
  assign out_last  = out_valid && (index_reg == LAST_IDX);
  assign busy      = (state_reg != ST_IDLE);
  assign timeout   = timeout_reg;
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_neuron_readout_3x5.sv
// Self-checking bench for neuron_readout_3x5: expected pixels are pushed to a
// scoreboard queue at capture time and popped as the DUT streams them out.
module tb_neuron_readout_3x5;

  localparam int MAXC = 20;

  logic         sclk = 1'b0;
  logic         re_n = 1'b0;
  logic         start = 1'b0;
  logic         state_cheak = 1'b0;
  logic [0:14]  state_changed = '0;
  logic [0:59]  phi_out = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic         out_pixel;
  logic [3:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         timeout;
  logic         done;

  neuron_readout_3x5 #(
    .N_NEUR(15), .PW(4), .STABLE_CHECKS(8), .MAX_CHECKS(MAXC)
  ) dut (
    .sclk(sclk), .re_n(re_n), .start(start), .state_cheak(state_cheak),
    .state_changed(state_changed), .phi_out(phi_out), .out_ready(out_ready),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_index(out_index),
    .out_last(out_last), .busy(busy), .timeout(timeout), .done(done)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic       pixel;
    logic [3:0] index;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] ph [15];
  int         m_stable = 0;
  int         m_check = 0;
  logic       m_to = 1'b0;

  task automatic step();
    @(negedge sclk);
  endtask

  task automatic drive_phases();
    for (int i = 0; i < 15; i++) phi_out[4*i +: 4] = ph[i];
  endtask

  task automatic set_all_phases(input logic [3:0] v);
    for (int i = 0; i < 15; i++) ph[i] = v;
  endtask

  function automatic logic pix_model(input logic [3:0] p, input logic [3:0] r);
    logic [3:0] d;
    d = p - r;
    return (d >= 4'd4) && (d <= 4'd11);
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_stable = 0;
    m_check = 0;
    m_to = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL start_timeout_clr: got %b want 0", timeout); end
    $display("start: busy=%b timeout=%b", busy, timeout);
  endtask

  task automatic strobe(input logic [0:14] chg);
    logic cap;
    exp_t e;
    drive_phases();
    state_cheak = 1'b1;
    state_changed = chg;
    m_check++;
    m_stable = (|chg) ? 0 : ((m_stable == 8) ? 8 : m_stable + 1);
    cap = (m_stable == 8) || (m_check == MAXC);
    if ((m_stable != 8) && (m_check == MAXC)) m_to = 1'b1;
    if (cap) begin
      for (int i = 0; i < 15; i++) begin
        e.pixel = pix_model(ph[i], ph[0]);
        e.index = 4'(i);
        e.last  = (i == 14);
        exp_q.push_back(e);
      end
    end
    step();
    state_cheak = 1'b0;
    state_changed = '0;
    checks++;
    if (out_valid !== cap) begin
      errors++;
      $display("FAIL strobe_valid: check %0d got valid=%b want %b", m_check, out_valid, cap);
    end
    if (cap) begin
      checks++;
      if (out_index !== 4'd0) begin errors++; $display("FAIL capture_index: got %0d want 0", out_index); end
      checks++;
      if (timeout !== m_to) begin errors++; $display("FAIL capture_timeout: got %b want %b", timeout, m_to); end
    end
    $display("strobe %0d: chg=%h stable=%0d valid=%b", m_check, chg, m_stable, out_valid);
  endtask

  // Streams out one capture; mode 0 = ready always high, 1 = ready 1,0,0 repeating.
  task automatic drain(input int mode, input bit start_during);
    int   xfers;
    int   cyc;
    logic stalled;
    logic pp;
    logic [3:0] pi;
    logic pl;
    exp_t e;
    xfers = 0; cyc = 0; stalled = 1'b0; pp = 1'b0; pi = 4'd0; pl = 1'b0;
    while (xfers < 15 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      start = (start_during && cyc == 4);
      if (stalled) begin
        checks++;
        if ({out_pixel, out_index, out_last} !== {pp, pi, pl}) begin
          errors++;
          $display("FAIL stall_hold: got %b/%0d/%b want %b/%0d/%b", out_pixel, out_index, out_last, pp, pi, pl);
        end
      end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: cycle %0d got %b want 1", cyc, out_valid); end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got index %0d want no transfer", out_index);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({out_pixel, out_index, out_last} !== {e.pixel, e.index, e.last}) begin
            errors++;
            $display("FAIL xfer: got pix=%b idx=%0d last=%b want pix=%b idx=%0d last=%b",
                     out_pixel, out_index, out_last, e.pixel, e.index, e.last);
          end
          $display("xfer idx=%0d pix=%b last=%b", out_index, out_pixel, out_last);
        end
        xfers++;
      end
      stalled = !out_ready;
      pp = out_pixel; pi = out_index; pl = out_last;
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (xfers != 15) begin errors++; $display("FAIL stream_budget: got %0d transfers want 15", xfers); end
    checks++;
    if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL done_pulse: got done=%b valid=%b want 1/0", done, out_valid); end
    checks++;
    if (timeout !== m_to) begin errors++; $display("FAIL done_timeout: got %b want %b", timeout, m_to); end
    step();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL after_done: got done=%b busy=%b want 0/0", done, busy); end
    checks++;
    if (timeout !== m_to) begin errors++; $display("FAIL idle_timeout: got %b want %b", timeout, m_to); end
    $display("stream complete: %0d transfers, timeout=%b", xfers, timeout);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({out_valid, out_pixel, out_index, out_last, busy, timeout, done} !== 10'd0) begin
      errors++;
      $display("FAIL %s: got v=%b p=%b i=%0d l=%b b=%b t=%b d=%b want all 0", tag,
               out_valid, out_pixel, out_index, out_last, busy, timeout, done);
    end
    $display("%s: outputs checked", tag);
  endtask

  task automatic test_reset();
    step();
    check_all_zero("reset_state");
    re_n = 1'b1;
    step();
  endtask

  task automatic test_convergence();
    set_all_phases(4'd3);
    ph[2] = 4'd11;
    do_start();
    for (int k = 0; k < 8; k++) strobe(15'd0);
    drain(0, 1'b0);
  endtask

  task automatic test_stability();
    logic [0:14] c;
    set_all_phases(4'd7);
    ph[4] = 4'd12;
    ph[9] = 4'd1;
    do_start();
    for (int k = 0; k < 7; k++) strobe(15'd0);
    c = '0;
    c[5] = 1'b1;
    strobe(c);
    for (int k = 0; k < 8; k++) strobe(15'd0);
    checks++;
    if (m_check != 16) begin errors++; $display("FAIL stab_check_cnt: got %0d want 16", m_check); end
    drain(0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [0:14] c;
    set_all_phases(4'd0);
    ph[7] = 4'd6;
    do_start();
    for (int k = 1; k <= MAXC; k++) begin
      c = '0;
      c[0] = (k % 2 == 1);
      strobe(c);
    end
    drain(0, 1'b0);
    do_start();
    for (int k = 0; k < 8; k++) strobe(15'd0);
    drain(0, 1'b0);
  endtask

  task automatic test_wrap();
    set_all_phases(4'd14);
    ph[1] = 4'd1; ph[2] = 4'd2; ph[3] = 4'd5; ph[4] = 4'd9; ph[5] = 4'd13;
    do_start();
    for (int k = 0; k < 8; k++) strobe(15'd0);
    // Phases moving after capture must not disturb the stream.
    for (int i = 0; i < 15; i++) ph[i] = 4'($urandom_range(0, 15));
    drive_phases();
    drain(0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 15; i++) ph[i] = 4'($urandom_range(0, 15));
    do_start();
    for (int k = 0; k < 8; k++) strobe(15'd0);
    drain(1, 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    int cyc;
    set_all_phases(4'd5);
    ph[3] = 4'd10;
    do_start();
    for (int k = 0; k < 8; k++) strobe(15'd0);
    cyc = 0;
    out_ready = 1'b1;
    while (out_index != 4'd6 && cyc < 50) begin
      step();
      cyc++;
    end
    checks++;
    if (out_index !== 4'd6) begin errors++; $display("FAIL reach_index6: got %0d want 6", out_index); end
    re_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    out_ready = 1'b0;
    exp_q.delete();
    step();
    re_n = 1'b1;
    step();
    check_all_zero("after_release");
    set_all_phases(4'd2);
    ph[8] = 4'd9;
    do_start();
    for (int k = 0; k < 8; k++) strobe(15'd0);
    drain(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_convergence();
    test_stability();
    test_timeout();
    test_wrap();
    test_backpressure();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_readout_3x5.md
# neuron_readout_3x5

Readout controller at the output side of the 15-neuron 3x5 oscillator bank. Monitors per-neuron `state_changed` flags at each `state_cheak` strobe, declares convergence after a run of consecutive stable checks (or a timeout), snapshots the 60-bit `phi_out` phase vector, and converts each phase relative to neuron 0 into a binary pixel. The 15 pixels are streamed out one per transfer over a valid/ready handshake to the host/UART side.

## Interface
- `N_NEUR`, 15, number of neurons; index 0 is the phase reference.
- `PW`, 4, phase width per neuron in bits.
- `STABLE_CHECKS`, 8, consecutive stable checks required for convergence (1..255).
- `MAX_CHECKS`, 1023, total checks before timeout (1..65535).

Ports:
- `sclk` in 1: system clock; all logic on the rising edge.
- `re_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that arms a readout; honoured only in IDLE.
- `state_cheak` in 1: one-cycle check strobe from the bank control.
- `state_changed` in [0:14]: per-neuron change flags; sampled only when `state_cheak`=1.
- `phi_out` in [0:59]: neuron i phase on `phi_out[4*i +: 4]`.
- `out_ready` in 1: downstream ready.
- `out_valid` out 1: pixel valid.
- `out_pixel` out 1: pixel value.
- `out_index` out 4: neuron index 0..14 of the current pixel.
- `out_last` out 1: high with index 14.
- `busy` out 1: high in every state except IDLE.
- `timeout` out 1: sticky; set when the run ended by `MAX_CHECKS`; cleared on accepted `start` or reset.
- `done` out 1: one-cycle pulse after the last transfer.

## Operation
- States: IDLE, WATCH, STREAM, DONE.
- IDLE: `start` clears `stable_cnt` (8 bit), `check_cnt` (16 bit), and `timeout`, then moves to WATCH.
- WATCH, on each `state_cheak`=1 cycle:
  - `check_cnt` increments.
  - If any `state_changed` bit is set, `stable_cnt` clears to 0; otherwise it increments, saturating at `STABLE_CHECKS`.
  - Convergence is when the new `stable_cnt` equals `STABLE_CHECKS`. Convergence takes priority over timeout.
  - Timeout is when there is no convergence and the new `check_cnt` equals `MAX_CHECKS`. `timeout` is set to 1.
  - On convergence or timeout, on that same edge: capture pixels from the current `phi_out`, set `out_index`=0, and go to STREAM.
  - Cycles with `state_cheak`=0 change nothing.
- Pixel decode: d_i = (phi_i − phi_0) mod 16, computed as a 4-bit wrap-around subtraction. Pixel_i = 1 iff 4 ≤ d_i ≤ 11. Pixel_0 is always 0.
- STREAM:
  - `out_valid`=1, with `out_pixel` = pixel[`out_index`].
  - A transfer occurs when `out_valid` & `out_ready`. It advances `out_index`.
  - The transfer at index 14 (with `out_last`=1) moves the FSM to DONE.
  - `out_pixel`, `out_index`, and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `state_cheak` outside WATCH is ignored.
- `re_n` low at any time, including mid-stream: immediate return to IDLE. Every output goes to 0 (`out_valid`, `out_pixel`, `out_index`, `out_last`, `busy`, `timeout`, `done`). Counters and the pixel register clear.

## Timing
- `start` in cycle k: `busy`=1 from k+1.
- Qualifying `state_cheak` in cycle c:
  - `out_valid`=1 and `out_index`=0 from c+1.
  - The captured phases are the `phi_out` values present in cycle c.
- With `out_ready` held at 1: 15 transfers in cycles c+1..c+15, `done`=1 in c+16, `busy`=0 from c+17.
- Each transfer occurs in a cycle where `out_valid`=`out_ready`=1. The next index appears in the following cycle.
- Minimum convergence time: `STABLE_CHECKS` strobes after entering WATCH.
- `phi_out` changes after capture do not affect the stream.

## Test plan
- Convergence: `start`, then 8 strobes with `state_changed`=0, phases phi_0=3, phi_1=3, phi_2=11, others 3, `out_ready`=1 → `out_valid` rises the cycle after the 8th strobe; pixels 0,0,1,0…0; `out_last` at index 14; `done` one cycle; `timeout`=0.
- Stability reset: 7 stable strobes, 1 strobe with bit 5 set, then 8 stable → stream begins only after the final 8; `check_cnt`=16 at capture.
- Timeout, with `MAX_CHECKS`=20: bit 0 toggles on every strobe → capture after the 20th strobe; `timeout`=1 stays high through DONE; cleared by the next `start`.
- Wrap-around decode: phi_0=14, phi_i = 1, 2, 5, 9, 13 → d = 3, 4, 7, 11, 15 → pixels 0, 1, 1, 1, 0.
- Backpressure: `out_ready` toggling 1,0,0,1… → 15 transfers total, no index skipped or repeated, outputs held during stalls; `start` pulse during STREAM ignored.
- Reset mid-stream: `re_n` low at index 6 → all outputs 0 asynchronously; after release, `start` plus 8 stable strobes gives a full 15-pixel stream from index 0.
